// File: rtl/marb_prio_arbiter.sv
// Client arbitration stage of the memory arbiter: picks one requester per memory
// transaction (static, round-robin or aged dynamic priority) and holds the grant until mem_done.
module marb_prio_arbiter #(
    parameter int MEM_ARB_CLIENTS_P = 3,
    parameter int AGE_W_P           = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  ctrl,
    input  logic [7:0]                   dprio0,
    input  logic [7:0]                   dprio1,
    input  logic [7:0]                   dprio2,
    input  logic [7:0]                   dprio3,
    input  logic [3:0]                   dprio_wstrb,
    input  logic [MEM_ARB_CLIENTS_P-1:0] cif_req,
    input  logic                         mem_done,
    output logic [MEM_ARB_CLIENTS_P-1:0] cif_gnt,
    output logic [1:0]                   gnt_id,
    output logic                         busy
);

    localparam int N     = MEM_ARB_CLIENTS_P;
    localparam int EFF_W = ((AGE_W_P > 8) ? AGE_W_P : 8) + 1;
    localparam logic [AGE_W_P-1:0] AGE_MAX = '1;

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [N-1:0]           r_gnt;
    logic [1:0]             r_gnt_id;
    logic [1:0]             r_last;

    logic                   w_arb_en;
    logic [1:0]             w_mode;
    logic [3:0]             w_req;
    logic [7:0]             w_dprio [4];
    logic [AGE_W_P-1:0]     w_age [4];
    logic [EFF_W-1:0]       w_eff [4];
    logic [1:0]             w_winner;
    logic [1:0]             w_scan;
    logic [EFF_W-1:0]       w_best;
    logic                   w_found;
    logic                   w_grant_now;
    logic [3:0]             w_onehot;
    logic                   w_unused;

    assign w_arb_en   = ctrl[0];
    assign w_mode     = ctrl[2:1];
    assign w_req      = 4'(cif_req);
    assign w_dprio[0] = dprio0;
    assign w_dprio[1] = dprio1;
    assign w_dprio[2] = dprio2;
    assign w_dprio[3] = dprio3;
    assign w_unused   = &{1'b0, ctrl[31:3], dprio_wstrb, w_onehot};

    // Absent clients never request, so their priorities can never win.
    for (genvar g = 0; g < 4; g++) begin : g_client
        if (g < N) begin : g_live
            logic [AGE_W_P-1:0] r_age;
            logic               w_served;

            assign w_served = (r_state == S_GRANT) && (r_gnt_id == 2'(g));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_age <= '0;
                end else if (!cif_req[g] || dprio_wstrb[g]) begin
                    r_age <= '0;
                end else if (w_grant_now && (w_winner == 2'(g))) begin
                    r_age <= '0;
                end else if (!w_served && (r_age != AGE_MAX)) begin
                    r_age <= r_age + AGE_W_P'(1);
                end
            end

            assign w_age[g] = r_age;
        end else begin : g_absent
            assign w_age[g] = '0;
        end
        assign w_eff[g] = EFF_W'(w_dprio[g]) + EFF_W'(w_age[g]);
    end

    always_comb begin
        w_winner = 2'd0;
        w_scan   = 2'd0;
        w_best   = '0;
        w_found  = 1'b0;
        case (w_mode)
            2'b01: begin
                for (int k = 1; k <= N; k++) begin
                    w_scan = 2'((int'(r_last) + k) % N);
                    if (!w_found && w_req[w_scan]) begin
                        w_winner = w_scan;
                        w_found  = 1'b1;
                    end
                end
            end
            2'b10: begin
                // Strict greater-than keeps the lowest index on a tie.
                for (int i = 0; i < 4; i++) begin
                    w_scan = 2'(i);
                    if (w_req[w_scan] && (!w_found || (w_eff[w_scan] > w_best))) begin
                        w_winner = w_scan;
                        w_best   = w_eff[w_scan];
                        w_found  = 1'b1;
                    end
                end
            end
            default: begin
                for (int i = 0; i < 4; i++) begin
                    w_scan = 2'(i);
                    if (!w_found && w_req[w_scan]) begin
                        w_winner = w_scan;
                        w_found  = 1'b1;
                    end
                end
            end
        endcase
    end

    assign w_grant_now = (r_state == S_IDLE) && w_arb_en && (|w_req);
    assign w_onehot    = 4'b0001 << w_winner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_now) w_next_state = S_GRANT;
            S_GRANT: if (mem_done)    w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // gnt_id is left holding after completion; it only has meaning while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt    <= '0;
            r_gnt_id <= 2'd0;
            r_last   <= 2'(N - 1);
        end else if (w_grant_now) begin
            r_gnt    <= w_onehot[N-1:0];
            r_gnt_id <= w_winner;
            r_last   <= w_winner;
        end else if ((r_state == S_GRANT) && mem_done) begin
            r_gnt    <= '0;
        end
    end

    assign cif_gnt = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign busy    = (r_state == S_GRANT);

endmodule

// File: tb/tb_marb_prio_arbiter.sv
// Self-checking bench for marb_prio_arbiter: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the arbitration rules.
module tb_marb_prio_arbiter;

    localparam int N       = 3;
    localparam int AGE_MAX = 255;

    logic        clk;
    logic        rst;
    logic [31:0] ctrl;
    logic [7:0]  dprio0, dprio1, dprio2, dprio3;
    logic [3:0]  wstrb;
    logic [2:0]  req;
    logic        memDone;
    logic [2:0]  cifGnt;
    logic [1:0]  gntId;
    logic        busy;

    // Second instance with a tiny age counter for the saturation scenario.
    logic [31:0] sCtrl;
    logic [7:0]  sDprio0, sDprio1, sDprioZero;
    logic [3:0]  sWstrb;
    logic [1:0]  sReq;
    logic        sDone;
    logic [1:0]  sGnt;
    logic [1:0]  sGntId;
    logic        sBusy;

    int total;
    int bad;

    int mOwner;
    int mGntId;
    int mLast;
    int mAge [N];

    marb_prio_arbiter #(.MEM_ARB_CLIENTS_P(3), .AGE_W_P(8)) dut (
        .clk(clk), .rst(rst), .ctrl(ctrl),
        .dprio0(dprio0), .dprio1(dprio1), .dprio2(dprio2), .dprio3(dprio3),
        .dprio_wstrb(wstrb), .cif_req(req), .mem_done(memDone),
        .cif_gnt(cifGnt), .gnt_id(gntId), .busy(busy)
    );

    marb_prio_arbiter #(.MEM_ARB_CLIENTS_P(2), .AGE_W_P(2)) dutSat (
        .clk(clk), .rst(rst), .ctrl(sCtrl),
        .dprio0(sDprio0), .dprio1(sDprio1), .dprio2(sDprioZero), .dprio3(sDprioZero),
        .dprio_wstrb(sWstrb), .cif_req(sReq), .mem_done(sDone),
        .cif_gnt(sGnt), .gnt_id(sGntId), .busy(sBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner index (-1 when free), round-robin pointer and plain integer ages.
    always @(posedge clk or posedge rst) begin
        int win;
        int best;
        int idx;
        int dp [4];
        bit granting;
        if (rst) begin
            mOwner <= -1;
            mGntId <= 0;
            mLast  <= N - 1;
            for (int i = 0; i < N; i++) mAge[i] <= 0;
        end else begin
            dp[0] = int'(dprio0);
            dp[1] = int'(dprio1);
            dp[2] = int'(dprio2);
            dp[3] = int'(dprio3);
            granting = (mOwner < 0) && ctrl[0] && (req != 3'b000);
            win = -1;
            if (ctrl[2:1] == 2'b01) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (mLast + k) % N;
                    if (win < 0 && req[idx]) win = idx;
                end
            end else if (ctrl[2:1] == 2'b10) begin
                best = -1;
                for (int i = 0; i < N; i++) begin
                    if (req[i] && (dp[i] + mAge[i] > best)) begin
                        best = dp[i] + mAge[i];
                        win  = i;
                    end
                end
            end else begin
                for (int i = 0; i < N; i++) if (win < 0 && req[i]) win = i;
            end
            for (int i = 0; i < N; i++) begin
                if (!req[i] || wstrb[i] || (granting && win == i)) mAge[i] <= 0;
                else if (mOwner != i && mAge[i] < AGE_MAX) mAge[i] <= mAge[i] + 1;
            end
            if (mOwner >= 0) begin
                if (memDone) mOwner <= -1;
            end else if (granting) begin
                mOwner <= win;
                mGntId <= win;
                mLast  <= win;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        rst = 1'b1;
        ctrl = 32'h0; req = 3'b000; memDone = 1'b0; wstrb = 4'b0000;
        sCtrl = 32'h0; sReq = 2'b00; sDone = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic drain;
        req = 3'b000;
        memDone = 1'b1;
        tick;
        memDone = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ctrl = 32'h1; req = 3'b111; memDone = 1'b0;
        tick;
        tick;
        total++;
        if (cifGnt !== 3'b000) begin bad++; $display("[TB] FAIL reset_gnt: got %b want 000", cifGnt); end
        total++;
        if (gntId !== 2'd0) begin bad++; $display("[TB] FAIL reset_gnt_id: got %0d want 0", gntId); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        ctrl = 32'h0; req = 3'b000;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_static;
        doReset;
        ctrl = 32'h1; req = 3'b110;
        tick;
        total++;
        if (cifGnt !== 3'b010) begin bad++; $display("[TB] FAIL static_gnt: got %b want 010", cifGnt); end
        total++;
        if (gntId !== 2'd1 || busy !== 1'b1) begin bad++; $display("[TB] FAIL static_id_busy: got id=%0d busy=%b want id=1 busy=1", gntId, busy); end
        req = 3'b001; ctrl = 32'h3;
        tick;
        tick;
        total++;
        if (cifGnt !== 3'b010 || gntId !== 2'd1) begin bad++; $display("[TB] FAIL static_hold: got %b/%0d want 010/1", cifGnt, gntId); end
        memDone = 1'b1; req = 3'b101;
        tick;
        memDone = 1'b0; ctrl = 32'h1;
        total++;
        if (busy !== 1'b0 || cifGnt !== 3'b000) begin bad++; $display("[TB] FAIL static_done: got busy=%b gnt=%b want 0/000", busy, cifGnt); end
        tick;
        total++;
        if (busy !== 1'b1 || gntId !== 2'd0) begin bad++; $display("[TB] FAIL static_regrant: got busy=%b id=%0d want 1/0", busy, gntId); end
        drain;
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL static_drain: got %b want 0", busy); end
    endtask

    task automatic test_round_robin;
        int expOrder [4];
        expOrder = '{0, 1, 2, 0};
        doReset;
        ctrl = 32'h3; req = 3'b111;
        for (int g = 0; g < 4; g++) begin
            tick;
            total++;
            if (busy !== 1'b1 || int'(gntId) != expOrder[g]) begin
                bad++;
                $display("[TB] FAIL rr_order[%0d]: got busy=%b id=%0d want 1/%0d", g, busy, gntId, expOrder[g]);
            end
            tick;
            memDone = 1'b1;
            tick;
            memDone = 1'b0;
        end
        tick;
        total++;
        if (gntId !== 2'd1) begin bad++; $display("[TB] FAIL rr_before_reset: got %0d want 1", gntId); end
        #3 rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || cifGnt !== 3'b000) begin bad++; $display("[TB] FAIL rr_async_reset: got busy=%b gnt=%b want 0/000", busy, cifGnt); end
        #1 rst = 1'b0;
        tick;
        total++;
        if (busy !== 1'b1 || gntId !== 2'd0) begin bad++; $display("[TB] FAIL rr_after_reset: got busy=%b id=%0d want 1/0", busy, gntId); end
        drain;
    endtask

    task automatic test_dynamic_tie;
        doReset;
        ctrl = 32'h5; dprio0 = 8'd10; dprio1 = 8'd40; dprio2 = 8'd40; req = 3'b111;
        tick;
        total++;
        if (cifGnt !== 3'b010 || gntId !== 2'd1) begin bad++; $display("[TB] FAIL dyn_tie: got %b/%0d want 010/1", cifGnt, gntId); end
        drain;
    endtask

    // Variant 0: plain aging; 1: priority rewritten before the decision; 2: rewritten on the decision cycle.
    task automatic test_dynamic_aging;
        int expWin [3];
        expWin = '{2, 0, 2};
        for (int v = 0; v < 3; v++) begin
            doReset;
            ctrl = 32'h5; dprio0 = 8'd100; dprio1 = 8'd0; dprio2 = 8'd90; req = 3'b101;
            tick;
            total++;
            if (gntId !== 2'd0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL age_first[%0d]: got id=%0d busy=%b want 0/1", v, gntId, busy); end
            repeat (14) tick;
            memDone = 1'b1;
            if (v == 1) wstrb = 4'b0100;
            tick;
            memDone = 1'b0; wstrb = 4'b0000;
            if (v == 2) wstrb = 4'b0100;
            tick;
            wstrb = 4'b0000;
            total++;
            if (busy !== 1'b1 || int'(gntId) != expWin[v]) begin
                bad++;
                $display("[TB] FAIL age_winner[%0d]: got busy=%b id=%0d want 1/%0d", v, busy, gntId, expWin[v]);
            end
            drain;
        end
    endtask

    task automatic test_disable;
        doReset;
        ctrl = 32'h0; req = 3'b111;
        for (int c = 0; c < 20; c++) begin
            tick;
            total++;
            if (busy !== 1'b0 || cifGnt !== 3'b000) begin bad++; $display("[TB] FAIL dis_idle[%0d]: got busy=%b gnt=%b want 0/000", c, busy, cifGnt); end
        end
        ctrl = 32'h1;
        tick;
        ctrl = 32'h0;
        total++;
        if (busy !== 1'b1 || gntId !== 2'd0) begin bad++; $display("[TB] FAIL dis_grant: got busy=%b id=%0d want 1/0", busy, gntId); end
        tick;
        tick;
        total++;
        if (busy !== 1'b1 || cifGnt !== 3'b001) begin bad++; $display("[TB] FAIL dis_outstanding: got busy=%b gnt=%b want 1/001", busy, cifGnt); end
        memDone = 1'b1;
        tick;
        memDone = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick;
            total++;
            if (busy !== 1'b0) begin bad++; $display("[TB] FAIL dis_no_regrant[%0d]: got busy=%b want 0", c, busy); end
        end
        req = 3'b000;
    endtask

    // Client 1 starves for 12 cycles: saturated age 3 gives 6 > 5, a wrapped age 0 would lose.
    task automatic test_age_saturation;
        doReset;
        sCtrl = 32'h5; sDprio0 = 8'd5; sDprio1 = 8'd3; sReq = 2'b11;
        tick;
        total++;
        if (sGntId !== 2'd0 || sBusy !== 1'b1) begin bad++; $display("[TB] FAIL sat_first: got id=%0d busy=%b want 0/1", sGntId, sBusy); end
        repeat (10) tick;
        sDone = 1'b1;
        tick;
        sDone = 1'b0;
        tick;
        total++;
        if (sGnt !== 2'b10 || sGntId !== 2'd1) begin bad++; $display("[TB] FAIL sat_winner: got %b/%0d want 10/1", sGnt, sGntId); end
        sReq = 2'b00; sDone = 1'b1;
        tick;
        sDone = 1'b0;
    endtask

    task automatic test_random;
        logic [2:0] expGnt;
        doReset;
        for (int c = 0; c < 500; c++) begin
            ctrl    = {29'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 7) != 0)};
            req     = 3'($urandom);
            dprio0  = 8'($urandom_range(0, 40));
            dprio1  = 8'($urandom_range(0, 40));
            dprio2  = 8'($urandom_range(0, 40));
            dprio3  = 8'($urandom);
            wstrb   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            memDone = ($urandom_range(0, 3) == 0);
            if (c == 250) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
            tick;
            expGnt = (mOwner >= 0) ? 3'(1 << mOwner) : 3'b000;
            total++;
            if (busy !== (mOwner >= 0)) begin bad++; $display("[TB] FAIL rnd_busy[%0d]: got %b want %b", c, busy, mOwner >= 0); end
            total++;
            if (cifGnt !== expGnt) begin bad++; $display("[TB] FAIL rnd_gnt[%0d]: got %b want %b", c, cifGnt, expGnt); end
            if (mOwner >= 0) begin
                total++;
                if (int'(gntId) != mGntId) begin bad++; $display("[TB] FAIL rnd_gnt_id[%0d]: got %0d want %0d", c, gntId, mGntId); end
            end
        end
        drain;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        ctrl = 32'h0; req = 3'b000; memDone = 1'b0; wstrb = 4'b0000;
        dprio0 = 8'd0; dprio1 = 8'd0; dprio2 = 8'd0; dprio3 = 8'd0;
        sCtrl = 32'h0; sDprio0 = 8'd0; sDprio1 = 8'd0; sDprioZero = 8'd0;
        sWstrb = 4'b0000; sReq = 2'b00; sDone = 1'b0;
        #1;
        test_reset;
        test_static;
        test_round_robin;
        test_dynamic_tie;
        test_dynamic_aging;
        test_disable;
        test_age_saturation;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
